// File: rtl/operand_entry_ctrl_if.sv
// Board-side bundle for the calculator operand entry front end.
// The master drives the switches and keys; the slave returns the operands, the operator and the entry state.
interface operand_entry_ctrl_if;
  logic [3:0] sw;
  logic [1:0] key_n;
  logic [3:0] a0;
  logic [3:0] a1;
  logic       op_sub;
  logic [1:0] state;
  logic       result_vld;

  modport master (
    output sw, key_n,
    input  a0, a1, op_sub, state, result_vld
  );

  modport slave (
    input  sw, key_n,
    output a0, a1, op_sub, state, result_vld
  );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Calculator input front end: synchronises sw/key_n, debounces the keys, and captures operands with an A0 -> A1 -> DONE FSM.
// Optional macro LIVE_PREVIEW_EN: the operand being entered follows the synchronised switches until ENTER.
module operand_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  operand_entry_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    GET_A0  = 2'b00,
    GET_A1  = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  logic [1:0] key_p0, key_p1;
  logic [3:0] sw_p0, sw_p1;
  logic [1:0] press;

  state_t     state_q, state_n;
  logic [3:0] a0_q, a0_n, a1_q, a1_n;
  logic       op_q, op_n, vld_q, vld_n;

  // Stage p0/p1: two-flop synchronisers. Keys reset to the pressed level, so a key
  // held through reset never shows a released sample and cannot arm itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 2'b00;
      key_p1 <= 2'b00;
    end else begin
      key_p0 <= bus.key_n;
      key_p1 <= key_p0;
    end
  end

  always_ff @(posedge clk) begin
    sw_p0 <= bus.sw;
    sw_p1 <= sw_p0;
  end

  // Debounce per key: count while the synced level disagrees with the accepted level.
  // A press is only reported once the key has been seen released since reset.
  for (genvar k = 0; k < 2; k++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             deb;
    logic             armed;
    logic             accept;

    assign accept   = (key_p1[k] != deb) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign press[k] = accept && deb && armed;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        deb   <= 1'b1;
        armed <= 1'b0;
      end else begin
        if (key_p1[k]) armed <= 1'b1;
        if (key_p1[k] == deb) begin
          cnt <= '0;
        end else if (accept) begin
          deb <= key_p1[k];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A0;
      a0_q    <= '0;
      a1_q    <= '0;
      op_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      a0_q    <= a0_n;
      a1_q    <= a1_n;
      op_q    <= op_n;
      vld_q   <= vld_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a0_n    = a0_q;
    a1_n    = a1_q;
    op_n    = op_q;
    vld_n   = vld_q;
    if (press[1]) op_n = ~op_q;
    case (state_q)
      GET_A0: begin
`ifdef LIVE_PREVIEW_EN
        a0_n = sw_p1;
`endif
        if (press[0]) begin
          a0_n    = sw_p1;
          state_n = GET_A1;
        end
      end
      GET_A1: begin
`ifdef LIVE_PREVIEW_EN
        a1_n = sw_p1;
`endif
        if (press[0]) begin
          a1_n    = sw_p1;
          vld_n   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (press[0]) begin
          a0_n    = '0;
          a1_n    = '0;
          vld_n   = 1'b0;
          state_n = GET_A0;
        end
      end
      default: begin
        a0_n    = '0;
        a1_n    = '0;
        vld_n   = 1'b0;
        state_n = GET_A0;
      end
    endcase
  end

  assign bus.a0         = a0_q;
  assign bus.a1         = a1_q;
  assign bus.op_sub     = op_q;
  assign bus.state      = state_q;
  assign bus.result_vld = vld_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl with a short debounce window (4 clks).
module tb_operand_entry_ctrl;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  operand_entry_ctrl_if bus ();

  operand_entry_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press(input int k);
    bus.key_n[k] = 1'b0;
    tick(10);
    bus.key_n[k] = 1'b1;
    tick(10);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] a0, input logic [3:0] a1,
                         input logic op, input logic [1:0] st, input logic vld);
    chk({tag, ".a0"},    {4'h0, bus.a0},     {4'h0, a0});
    chk({tag, ".a1"},    {4'h0, bus.a1},     {4'h0, a1});
    chk({tag, ".op"},    {7'h0, bus.op_sub}, {7'h0, op});
    chk({tag, ".state"}, {6'h0, bus.state},  {6'h0, st});
    chk({tag, ".vld"},   {7'h0, bus.result_vld}, {7'h0, vld});
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b1;
    bus.sw    = 4'h0;
    bus.key_n = 2'b11;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk_all("reset", 4'h0, 4'h0, 1'b0, 2'b00, 1'b0);

    // Operand entry
    bus.sw = 4'h3;
    tick(3);
    press(0);
    chk_all("enter_a0", 4'h3, 4'h0, 1'b0, 2'b01, 1'b0);
    bus.sw = 4'h9;
    tick(3);
    press(0);
    chk_all("enter_a1", 4'h3, 4'h9, 1'b0, 2'b10, 1'b1);

    // Switches alone never disturb captured operands
    bus.sw = 4'hF;
    tick(6);
    chk_all("sw_hold", 4'h3, 4'h9, 1'b0, 2'b10, 1'b1);

    // Three OP presses in DONE
    press(1);
    chk("op_first", {7'h0, bus.op_sub}, 8'h1);
    press(1);
    chk("op_second", {7'h0, bus.op_sub}, 8'h0);
    press(1);
    chk_all("op_done", 4'h3, 4'h9, 1'b1, 2'b10, 1'b1);

    // ENTER in DONE clears operands, keeps operator
    press(0);
    chk_all("done_clear", 4'h0, 4'h0, 1'b1, 2'b00, 1'b0);

    // Bouncing ENTER: 2-clk lows are rejected, final edge advances 6 clks later
    bus.sw = 4'h7;
    for (int i = 0; i < 10; i++) begin
      bus.key_n[0] = (i % 2 == 1);
      tick(2);
    end
    chk("bounce_ignored", {6'h0, bus.state}, 8'h00);
    bus.key_n[0] = 1'b0;
    tick(5);
    chk("bounce_before", {6'h0, bus.state}, 8'h00);
    tick(1);
    chk("bounce_advance", {6'h0, bus.state}, 8'h01);
    chk("bounce_a0", {4'h0, bus.a0}, 8'h07);
    tick(12);
    chk("held_no_repeat", {6'h0, bus.state}, 8'h01);
    bus.key_n[0] = 1'b1;
    tick(10);
    chk("release_no_event", {6'h0, bus.state}, 8'h01);

    // Simultaneous ENTER and OP in GET_A1
    bus.sw = 4'h5;
    tick(3);
    bus.key_n = 2'b00;
    tick(10);
    bus.key_n = 2'b11;
    tick(10);
    chk_all("simul", 4'h7, 4'h5, 1'b0, 2'b10, 1'b1);

    // Asynchronous reset mid-run with ENTER held across release
    bus.key_n[0] = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 4'h0, 4'h0, 1'b0, 2'b00, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    chk("held_across_reset", {6'h0, bus.state}, 8'h00);
    bus.key_n[0] = 1'b1;
    tick(10);
    chk("release_after_reset", {6'h0, bus.state}, 8'h00);
    bus.sw = 4'hA;
    tick(3);
    press(0);
    chk("repress_state", {6'h0, bus.state}, 8'h01);
    chk("repress_a0", {4'h0, bus.a0}, 8'h0A);

    // Switch sweep in GET_A0
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    for (int v = 0; v < 16; v++) begin
      bus.sw = 4'(v);
      tick(3);
`ifdef LIVE_PREVIEW_EN
      chk("preview_a0", {4'h0, bus.a0}, 8'(v));
`else
      chk("no_preview_a0", {4'h0, bus.a0}, 8'h00);
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
